// File: rtl/aes_dec_pkg.sv
// Shared types, round constants and S-box / GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   round_t;

  localparam round_t FINAL_ROUND = 4'd9;
  localparam round_t DONE_STATE  = 4'd10;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  // Byte k of a block is bits [127-8k -: 8]; state element (row r, column c) is byte r+4c.
  function automatic block_t inv_sub_bytes(input block_t b);
    block_t r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox(b[127-8*k -: 8]);
    return r;
  endfunction

  function automatic block_t inv_shift_rows(input block_t b);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = b[127-8*(rw+4*((c+4-rw)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e are all InvMixColumns needs).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_decryption_if.sv
// Block/FIFO/key-store bus of the AES-128 decryptor; blocks_done exists only with AES_DEC_BLOCK_COUNT_EN.
interface aes_decryption_if #(
  parameter int KEY_ADDR_W = 5
);
  import aes_dec_pkg::*;

  logic                  read_fifo;
  logic                  is_full;
  block_t                fifo_in;
  block_t                round_key_10;
  block_t                round_key_input;
  logic [KEY_ADDR_W-1:0] round_key_addr;
  logic                  ready;
  block_t                data_output;
  logic                  data_done;
`ifdef AES_DEC_BLOCK_COUNT_EN
  logic [15:0]           blocks_done;
`endif

  modport slave (
    input  read_fifo, is_full, fifo_in, round_key_10, round_key_input,
`ifdef AES_DEC_BLOCK_COUNT_EN
    output blocks_done,
`endif
    output round_key_addr, ready, data_output, data_done
  );

  modport master (
    output read_fifo, is_full, fifo_in, round_key_10, round_key_input,
`ifdef AES_DEC_BLOCK_COUNT_EN
    input  blocks_done,
`endif
    input  round_key_addr, ready, data_output, data_done
  );

endinterface

// File: rtl/aes_decryption_inv_mix_columns.sv
// InvMixColumns: each 32-bit column multiplied by the circulant {0e,0b,0d,09} over GF(2^8).
module aes_decryption_inv_mix_columns
  import aes_dec_pkg::*;
(
  input  block_t data_i,
  output block_t data_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[127-32*gi -: 8];
    assign a1 = data_i[119-32*gi -: 8];
    assign a2 = data_i[111-32*gi -: 8];
    assign a3 = data_i[103-32*gi -: 8];
    assign data_o[127-32*gi -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign data_o[119-32*gi -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign data_o[111-32*gi -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign data_o[103-32*gi -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  end

endmodule

// File: rtl/aes_decryption.sv
// AES-128 inverse cipher: 3-stage recirculating pipeline, up to 3 interleaved blocks, 10 passes each.
// Optional AES_DEC_BLOCK_COUNT_EN adds a saturating completed-block counter.
module aes_decryption #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              n_rst,
  aes_decryption_if.slave   bus
);
  import aes_dec_pkg::*;

  localparam round_t DONE_ST  = round_t'(NUM_ROUNDS);
  localparam round_t FINAL_ST = round_t'(NUM_ROUNDS - 1);

  block_t block_a_q, block_b_q, block_c_q, round_key_q;
  round_t state_a_q, state_b_q, state_c_q;
  logic   valid_a_q, valid_b_q, valid_c_q;

  block_t block_a_d, block_c_d, sel_block, pre_block, ark_block, imc_block;
  round_t state_a_d, sel_state;
  logic   valid_a_d, ready, done;

  assign done  = valid_c_q && (state_c_q == DONE_ST);
  assign ready = !valid_c_q || (state_c_q == DONE_ST);

  // A finished block in C is never fed back: the slot goes to a new block or a bubble.
  always_comb begin
    sel_block = block_c_q;
    sel_state = state_c_q;
    valid_a_d = valid_c_q;
    if (ready) begin
      valid_a_d = bus.read_fifo;
      sel_state = '0;
      sel_block = bus.read_fifo ? bus.fifo_in : '0;
    end
    pre_block = (sel_state == '0) ? (sel_block ^ bus.round_key_10) : sel_block;
    block_a_d = inv_shift_rows(pre_block);
    state_a_d = sel_state;
  end

  assign ark_block = block_b_q ^ round_key_q;

  aes_decryption_inv_mix_columns u_imc (
    .data_i (ark_block),
    .data_o (imc_block)
  );

  assign block_c_d = (state_b_q == FINAL_ST) ? ark_block : imc_block;

  // Key fetched for the block in A lands in round_key_q together with that block in B.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      block_a_q   <= '0;
      block_b_q   <= '0;
      block_c_q   <= '0;
      round_key_q <= '0;
      state_a_q   <= '0;
      state_b_q   <= '0;
      state_c_q   <= '0;
      valid_a_q   <= 1'b0;
      valid_b_q   <= 1'b0;
      valid_c_q   <= 1'b0;
    end else if (!bus.is_full) begin
      block_a_q   <= block_a_d;
      state_a_q   <= state_a_d;
      valid_a_q   <= valid_a_d;
      block_b_q   <= inv_sub_bytes(block_a_q);
      state_b_q   <= state_a_q;
      valid_b_q   <= valid_a_q;
      round_key_q <= bus.round_key_input;
      block_c_q   <= block_c_d;
      state_c_q   <= state_b_q + round_t'(1);
      valid_c_q   <= valid_b_q;
    end
  end

  assign bus.round_key_addr = valid_a_q ? KEY_ADDR_W'(FINAL_ST - state_a_q) : '0;
  assign bus.ready          = ready;
  assign bus.data_done      = done;
  assign bus.data_output    = block_c_q;

`ifdef AES_DEC_BLOCK_COUNT_EN
  logic [15:0] blocks_done_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blocks_done_q <= '0;
    end else if (done && !bus.is_full && (blocks_done_q != 16'hFFFF)) begin
      blocks_done_q <= blocks_done_q + 16'd1;
    end
  end

  assign bus.blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_aes_decryption.sv
// Directed bench for aes_decryption: known-answer table, back-to-back interleave, stall and reset sequences.
module tb_aes_decryption;
  import aes_dec_pkg::*;

  typedef struct {
    block_t key;
    block_t ct;
    block_t pt;
  } vec_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic   clk;
  logic   n_rst;
  block_t rk_mem [11];
  vec_t   vecs [4];
  int     checks;
  int     errors;
  int     exp_blocks;

  aes_decryption_if #(.KEY_ADDR_W(5)) bus ();

  aes_decryption #(.NUM_ROUNDS(10), .KEY_ADDR_W(5)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared key store: rk_mem[r] is round key r, read combinationally.
  assign bus.round_key_10 = rk_mem[10];
  always_comb begin
    bus.round_key_input = '0;
    if (bus.round_key_addr < 5'd11) bus.round_key_input = rk_mem[int'(bus.round_key_addr)];
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[11'd2047 - {w[31:24], 3'b000} -: 8], SBOX[11'd2047 - {w[23:16], 3'b000} -: 8],
            SBOX[11'd2047 - {w[15:8], 3'b000} -: 8],  SBOX[11'd2047 - {w[7:0], 3'b000} -: 8]};
  endfunction

  task automatic load_key(input block_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accepting edge is counted as edge 1.
  task automatic inject(input block_t ct);
    bus.fifo_in   = ct;
    bus.read_fifo = 1'b1;
    step();
    bus.read_fifo = 1'b0;
  endtask

  task automatic wait_done(input int start, input int limit, output int edges);
    edges = start;
    while (bus.data_done !== 1'b1 && edges < limit) begin
      step();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end

  initial begin
    int         edges;
    logic       seen;
    logic [4:0] a0;
    block_t     d0;

    checks     = 0;
    errors     = 0;
    exp_blocks = 0;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt: 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'hf5d3d58503b9699de785895a96fdbaaf,
                pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};

    n_rst         = 1'b0;
    bus.read_fifo = 1'b0;
    bus.is_full   = 1'b0;
    bus.fifo_in   = '0;
    load_key(vecs[0].key);
    repeat (2) step();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.data_done, 1'b0);
    check("rst_addr", bus.round_key_addr, 5'd0);
    check("rst_data", bus.data_output, '0);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("rst_count", bus.blocks_done, 16'd0);
`endif
    n_rst = 1'b1;
    step();

    // Known-answer table, one block at a time.
    for (int i = 0; i < 4; i++) begin
      load_key(vecs[i].key);
      check($sformatf("vec%0d_ready", i), bus.ready, 1'b1);
      inject(vecs[i].ct);
      wait_done(1, 60, edges);
      check($sformatf("vec%0d_latency", i), edges, 30);
      check($sformatf("vec%0d_pt", i), bus.data_output, vecs[i].pt);
      $display("vec %0d ct=%h pt=%h edges=%0d", i, vecs[i].ct, bus.data_output, edges);
      step();
      check($sformatf("vec%0d_done_once", i), bus.data_done, 1'b0);
      exp_blocks++;
    end

    // Three injections on consecutive cycles, then a fourth attempt while busy.
    load_key(vecs[0].key);
    bus.read_fifo = 1'b1;
    bus.fifo_in = vecs[0].ct; step();
    bus.fifo_in = vecs[2].ct; step();
    bus.fifo_in = vecs[3].ct; step();
    check("b2b_ready_low", bus.ready, 1'b0);
    bus.fifo_in = vecs[1].ct;
    repeat (5) step();
    check("b2b_busy_ready", bus.ready, 1'b0);
    bus.read_fifo = 1'b0;
    wait_done(8, 80, edges);
    check("b2b_latency", edges, 30);
    for (int k = 0; k < 3; k++) begin
      d0 = (k == 0) ? vecs[0].pt : (k == 1) ? vecs[2].pt : vecs[3].pt;
      check($sformatf("b2b_done%0d", k), bus.data_done, 1'b1);
      check($sformatf("b2b_pt%0d", k), bus.data_output, d0);
      $display("b2b %0d pt=%h", k, bus.data_output);
      step();
      exp_blocks++;
    end
    check("b2b_done_end", bus.data_done, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.data_done) seen = 1'b1;
    end
    check("b2b_no_fourth", seen, 1'b0);

    // Seven-cycle stall while a block is in A; read_fifo offered during the stall.
    load_key(vecs[1].key);
    inject(vecs[1].ct);
    repeat (9) step();
    bus.is_full   = 1'b1;
    bus.read_fifo = 1'b1;
    bus.fifo_in   = vecs[0].ct;
    a0 = bus.round_key_addr;
    d0 = bus.data_output;
    check("stall_addr_valid", a0, 5'd6);
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("stall_addr%0d", k), bus.round_key_addr, a0);
      check($sformatf("stall_data%0d", k), bus.data_output, d0);
    end
    bus.read_fifo = 1'b0;
    bus.is_full   = 1'b0;
    wait_done(17, 90, edges);
    check("stall_latency", edges, 37);
    check("stall_pt", bus.data_output, vecs[1].pt);
    $display("stall pt=%h edges=%0d", bus.data_output, edges);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("stall_count_before", bus.blocks_done, 16'(exp_blocks));
`endif
    // Finished block held in C while downstream is full.
    bus.is_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("full_done_hold%0d", k), bus.data_done, 1'b1);
    end
    check("full_data_hold", bus.data_output, vecs[1].pt);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("full_count_hold", bus.blocks_done, 16'(exp_blocks));
`endif
    bus.is_full = 1'b0;
    step();
    exp_blocks++;
    check("full_release_done", bus.data_done, 1'b0);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("full_count_once", bus.blocks_done, 16'(exp_blocks));
`endif
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.data_done) seen = 1'b1;
    end
    check("stall_read_ignored", seen, 1'b0);

    // Asynchronous reset in the middle of pass 5.
    load_key(vecs[0].key);
    inject(vecs[0].ct);
    repeat (14) step();
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_done", bus.data_done, 1'b0);
    check("mid_rst_ready", bus.ready, 1'b1);
    check("mid_rst_addr", bus.round_key_addr, 5'd0);
    check("mid_rst_data", bus.data_output, '0);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("mid_rst_count", bus.blocks_done, 16'd0);
`endif
    exp_blocks = 0;
    repeat (2) step();
    n_rst = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      step();
      if (bus.data_done) seen = 1'b1;
    end
    check("post_rst_no_output", seen, 1'b0);
    load_key(vecs[1].key);
    inject(vecs[1].ct);
    wait_done(1, 60, edges);
    check("post_rst_latency", edges, 30);
    check("post_rst_pt", bus.data_output, vecs[1].pt);
    $display("post-reset pt=%h edges=%0d", bus.data_output, edges);
    step();
    exp_blocks++;
    check("post_rst_done_once", bus.data_done, 1'b0);
`ifdef AES_DEC_BLOCK_COUNT_EN
    check("post_rst_count", bus.blocks_done, 16'(exp_blocks));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
